// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL lock / reset sequencer: FSM state encoding and
// the width helper for the single dwell counter.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  // Counter must reach (largest cycle parameter - 1); never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser, async active-low reset, resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_rst_seq.sv
// PLL reset / lock-qualification sequencer on the free-running reference clock.
// Define PLL_SEQ_LOSS_CNT_EN to add the saturating loss_cnt port and counter.
module pll_lock_rst_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 96000,
  parameter int unsigned CNT_W               = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             soft_rst,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic [1:0]       state,
  output logic             timeout_err
`ifdef PLL_SEQ_LOSS_CNT_EN
  , output logic [CNT_W-1:0] loss_cnt
`endif
);

  localparam int CW = cnt_width(int'(PLL_RST_CYCLES), int'(LOCK_STABLE_CYCLES),
                                int'(LOCK_TIMEOUT_CYCLES));
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t RST_LAST    = cnt_t'(PLL_RST_CYCLES - 1);
  localparam cnt_t STABLE_LAST = cnt_t'(LOCK_STABLE_CYCLES - 1);
  localparam cnt_t TMO_LAST    = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);

  seq_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic       terr_q, terr_d;
  logic       pll_rst_q, sys_rst_n_q, ready_q;
  logic       locked_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    terr_d  = terr_q;
    if (soft_rst) begin
      state_d = PLL_RST;
      cnt_d   = '0;
      terr_d  = 1'b0;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABLE;
          end else if (cnt_q == TMO_LAST) begin
            state_d = PLL_RST;
            terr_d  = 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s)                state_d = WAIT_LOCK;
          else if (cnt_q == STABLE_LAST) state_d = RUN;
        end
        RUN: begin
          cnt_d = cnt_q;
          if (!locked_s) state_d = PLL_RST;
        end
        default: state_d = PLL_RST;
      endcase
    end
    // Every state change restarts the dwell counter.
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs decoded from next state so they move on the same edge as state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      terr_q      <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      terr_q      <= terr_d;
      pll_rst_q   <= (state_d == PLL_RST);
      sys_rst_n_q <= (state_d == RUN);
      ready_q     <= (state_d == RUN);
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst_n   = sys_rst_n_q;
  assign ready       = ready_q;
  assign state       = state_q;
  assign timeout_err = terr_q;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic             loss_inc;
  logic [CNT_W-1:0] loss_q;

  // soft_rst wins over a simultaneous loss, so that edge is not counted.
  assign loss_inc = !soft_rst && (state_q == RUN) && !locked_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else if (loss_inc && (loss_q != '1)) begin
      loss_q <= loss_q + 1'b1;
    end
  end

  assign loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Randomised and directed bench for pll_lock_rst_seq against a dwell-time model.
// Define PLL_SEQ_LOSS_CNT_EN to also check loss_cnt.
module tb_pll_lock_rst_seq;

  localparam int PR = 16;
  localparam int LS = 64;
  localparam int LT = 200;
  localparam int CW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_rst = 1'b0;
  logic       pll_rst, sys_rst_n, ready, timeout_err;
  logic [1:0] state;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [CW-1:0] loss_cnt;
`endif

  always #5 clk = ~clk;

  pll_lock_rst_seq #(
    .PLL_RST_CYCLES      (PR),
    .LOCK_STABLE_CYCLES  (LS),
    .LOCK_TIMEOUT_CYCLES (LT),
    .CNT_W               (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .soft_rst    (soft_rst),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .state       (state),
    .timeout_err (timeout_err)
`ifdef PLL_SEQ_LOSS_CNT_EN
    , .loss_cnt  (loss_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  bit chk_en = 1'b0;

  // Model: phase (0..3), cycles spent in the phase, sticky error, loss count,
  // and a two-deep delay line standing in for the synchroniser.
  int m_phase, m_dwell, m_terr, m_loss;
  bit lock_q[$];

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s edge=%0d actual=%0d required=%0d", name, edge_n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_dwell = 0; m_terr = 0; m_loss = 0;
    lock_q = {1'b0, 1'b0};
  endtask

  task automatic enter(input int p);
    m_phase = p;
    m_dwell = 0;
  endtask

  task automatic model_edge(input bit lk, input bit sr);
    bit ls;
    ls = lock_q.pop_front();
    lock_q.push_back(lk);
    if (sr) begin
      enter(0);
      m_terr = 0;
    end else begin
      m_dwell++;
      case (m_phase)
        0: if (m_dwell == PR) enter(1);
        1: begin
          if (ls) enter(2);
          else if (m_dwell == LT) begin enter(0); m_terr = 1; end
        end
        2: begin
          if (!ls) enter(1);
          else if (m_dwell == LS) enter(3);
        end
        default: if (!ls) begin enter(0); if (m_loss < 255) m_loss++; end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      model_edge(pll_locked, soft_rst);
      edge_n++;
    end else begin
      model_reset();
    end
    @(negedge clk);
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic hard_reset();
    #2 rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    edge_n = 0;
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cyc_state", state, m_phase);
        chk("cyc_pll_rst", pll_rst, (m_phase == 0) ? 1 : 0);
        chk("cyc_sys_rst_n", sys_rst_n, (m_phase == 3) ? 1 : 0);
        chk("cyc_ready", ready, (m_phase == 3) ? 1 : 0);
        chk("cyc_timeout_err", timeout_err, m_terr);
`ifdef PLL_SEQ_LOSS_CNT_EN
        chk("cyc_loss_cnt", loss_cnt, m_loss);
`endif
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_sys_rst_n", sys_rst_n, 0);
    chk("rst_ready", ready, 0);
    chk("rst_timeout_err", timeout_err, 0);
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk("rst_loss_cnt", loss_cnt, 0);
`endif
    chk_en = 1'b1;

    // Clean start with lock held high.
    pll_locked = 1'b1;
    rst_n = 1'b1;
    edge_n = 0;
    run_to(15);  chk("clean_pll_rst_e15", pll_rst, 1);
    run_to(16);  chk("clean_pll_rst_e16", pll_rst, 0); chk("clean_state_e16", state, 1);
    run_to(17);  chk("clean_state_e17", state, 2);
    run_to(80);  chk("clean_ready_e80", ready, 0);
    run_to(81);  chk("clean_ready_e81", ready, 1); chk("clean_sysrst_e81", sys_rst_n, 1);
    chk("clean_terr", timeout_err, 0);

    // Lock loss in RUN: three edges to system reset.
    run_to(100);
    pll_locked = 1'b0;
    run_to(102); chk("loss_ready_e2", ready, 1);
    run_to(103); chk("loss_ready_e3", ready, 0); chk("loss_sysrst_e3", sys_rst_n, 0);
    chk("loss_pll_rst_e3", pll_rst, 1);
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk("loss_cnt_1", loss_cnt, 1);
`endif

    // No lock: timeout and retry.
    pll_locked = 1'b0;
    hard_reset();
    run_to(215); chk("nolock_terr_e215", timeout_err, 0); chk("nolock_pll_rst_e215", pll_rst, 0);
    run_to(216); chk("nolock_terr_e216", timeout_err, 1); chk("nolock_pll_rst_e216", pll_rst, 1);
    run_to(231); chk("nolock_pll_rst_e231", pll_rst, 1);
    run_to(232); chk("nolock_pll_rst_e232", pll_rst, 0);
    run_to(500);

    // Simultaneous soft_rst and lock loss in RUN, with timeout_err still set.
    pll_locked = 1'b1;
    run_to(600);
    chk("simul_ready_pre", ready, 1);
    chk("simul_terr_pre", timeout_err, 1);
    pll_locked = 1'b0;
    tick();
    tick();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    chk("simul_state", state, 0);
    chk("simul_terr", timeout_err, 0);
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk("simul_loss_cnt", loss_cnt, 0);
`endif

    // Glitch while STABLE.
    pll_locked = 1'b1;
    hard_reset();
    run_to(47);
    pll_locked = 1'b0;
    run_to(50);  chk("glitch_state_e50", state, 1);
    run_to(52);
    pll_locked = 1'b1;
    run_to(54);  chk("glitch_state_e54", state, 1);
    run_to(55);  chk("glitch_state_e55", state, 2);
    run_to(118); chk("glitch_ready_e118", ready, 0);
    run_to(119); chk("glitch_ready_e119", ready, 1);
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk("glitch_loss_cnt", loss_cnt, 0);
`endif

    // soft_rst held high pins the FSM in PLL_RST.
    hard_reset();
    run_to(30);
    soft_rst = 1'b1;
    run_to(50);  chk("hold_state", state, 0); chk("hold_pll_rst", pll_rst, 1);
    soft_rst = 1'b0;
    run_to(65);  chk("hold_pll_rst_e65", pll_rst, 1);
    run_to(66);  chk("hold_pll_rst_e66", pll_rst, 0);

    // Async reset in the middle of STABLE, between clock edges.
    hard_reset();
    run_to(40);
    chk("async_state_pre", state, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", state, 0);
    chk("async_pll_rst", pll_rst, 1);
    chk("async_sys_rst_n", sys_rst_n, 0);
    chk("async_ready", ready, 0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    edge_n = 0;
    run_to(16);  chk("async_restart_e16", state, 1);
    run_to(80);  chk("async_ready_e80", ready, 0);
    run_to(81);  chk("async_ready_e81", ready, 1);

`ifdef PLL_SEQ_LOSS_CNT_EN
    // Saturation of the loss counter.
    hard_reset();
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      for (int k = 0; k < 200 && !ready; k++) tick();
      chk("sat_relock", ready, 1);
      pll_locked = 1'b0;
      repeat (3) tick();
    end
    chk("sat_loss_cnt", loss_cnt, 255);
`endif

    // Randomised lock behaviour with occasional soft resets.
    hard_reset();
    pll_locked = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      soft_rst = ($urandom_range(0, 299) == 0);
      if (pll_locked) begin
        if ($urandom_range(0, 149) == 0) pll_locked = 1'b0;
      end else begin
        if ($urandom_range(0, 29) == 0) pll_locked = 1'b1;
      end
      tick();
    end
    soft_rst = 1'b0;

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
